alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one RV32 ALU instruction, decodes it, drives the ALU, returns the result.
// Latency: the result is offered two edges after the accept edge. Only one instruction is in flight, and the controller holds it in RESP until res_ready.
module alu_issue_ctrl #(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [31:0]         instr,
  input  logic [WIDTH-1:0]    rs1_data,
  input  logic [WIDTH-1:0]    rs2_data,
  output logic [OP_WIDTH-1:0] alu_op,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  input  logic [WIDTH-1:0]    alu_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [WIDTH-1:0]    res_data,
  output logic [4:0]          res_rd,
  output logic                res_illegal,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESP} state_t;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  state_t             state;
  logic [11:0]        hi_q;     // instr[31:20]: funct7 for R-type, immediate for I-type
  logic [2:0]         funct3_q;
  logic [4:0]         rd_q;
  logic [6:0]         opcode_q;
  logic [WIDTH-1:0]   rs1_q;
  logic [WIDTH-1:0]   rs2_q;

  logic               dec_legal;
  logic [OP_WIDTH-1:0] dec_op;
  logic [WIDTH-1:0]   dec_b;
  logic [6:0]         funct7;

  // Source register index fields are resolved upstream; only the data is used here.
  logic unused_rs_idx;
  assign unused_rs_idx = ^instr[19:15];

  assign funct7 = hi_q[11:5];

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = '0;
    dec_b     = '0;
    if (opcode_q == OPC_R) begin
      dec_b = rs2_q;
      if (funct7 == 7'b0000000) begin
        dec_legal = 1'b1;
        case (funct3_q)
          3'b000:  dec_op = OP_WIDTH'(1);
          3'b111:  dec_op = OP_WIDTH'(3);
          3'b110:  dec_op = OP_WIDTH'(4);
          3'b100:  dec_op = OP_WIDTH'(5);
          default: dec_legal = 1'b0;
        endcase
      end else if (funct7 == 7'b0100000 && funct3_q == 3'b000) begin
        dec_legal = 1'b1;
        dec_op    = OP_WIDTH'(2);
      end
    end else if (opcode_q == OPC_I) begin
      dec_b     = {{(WIDTH-12){hi_q[11]}}, hi_q};
      dec_legal = 1'b1;
      case (funct3_q)
        3'b000:  dec_op = OP_WIDTH'(1);
        3'b111:  dec_op = OP_WIDTH'(3);
        3'b110:  dec_op = OP_WIDTH'(4);
        3'b100:  dec_op = OP_WIDTH'(5);
        default: dec_legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hi_q        <= '0;
      funct3_q    <= '0;
      rd_q        <= '0;
      opcode_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      instr_ready <= 1'b0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_rd      <= '0;
      res_illegal <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          instr_ready <= 1'b1;
          if (instr_valid && instr_ready) begin
            hi_q        <= instr[31:20];
            funct3_q    <= instr[14:12];
            rd_q        <= instr[11:7];
            opcode_q    <= instr[6:0];
            rs1_q       <= rs1_data;
            rs2_q       <= rs2_data;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= DECODE;
          end
        end
        DECODE: begin
          alu_op      <= dec_legal ? dec_op : '0;
          alu_a       <= dec_legal ? rs1_q : '0;
          alu_b       <= dec_legal ? dec_b : '0;
          res_rd      <= rd_q;
          res_illegal <= ~dec_legal;
          state       <= EXEC;
        end
        EXEC: begin
          // Writes to x0 and illegal instructions return zero regardless of the ALU.
          res_data  <= (res_illegal || res_rd == 5'd0) ? '0 : alu_out;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            alu_op      <= '0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
